// File: rtl/quaternion_divider_if.sv
// Operand/result handshake bundle for the quaternion divider.
// The producer/consumer side uses master; the divider uses slave.
interface quaternion_divider_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] b0, b1, b2, b3;
  logic signed [15:0] y0, y1, y2, y3;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] x0, x1, x2, x3;
  logic               div_by_zero;

  modport master (
    output in_valid, b0, b1, b2, b3, y0, y1, y2, y3, out_ready,
    input  in_ready, out_valid, x0, x1, x2, x3, div_by_zero
  );

  modport slave (
    input  in_valid, b0, b1, b2, b3, y0, y1, y2, y3, out_ready,
    output in_ready, out_valid, x0, x1, x2, x3, div_by_zero
  );
endinterface

// File: rtl/quaternion_divider.sv
// Sequential quaternion left division: x = conj(b) (x) y / |b|^2.
// Four restoring dividers share the norm and retire one quotient bit per cycle.
module quaternion_divider (
  input  logic                 clk,
  input  logic                 rst_n,
  quaternion_divider_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_PROD, S_DIV, S_FIN, S_OUT} state_t;

  state_t             r_state, w_next;
  logic signed [15:0] r_b [4];
  logic signed [15:0] r_y [4];
  logic [32:0]        r_mag [4];
  logic [3:0]         r_sgn;
  logic [32:0]        r_n;
  logic [32:0]        r_rem [4];
  logic [32:0]        r_q [4];
  logic [5:0]         r_cnt;
  logic               r_zero;
  logic signed [15:0] r_x [4];
  logic               r_ovld;
  logic               r_dbz;

  logic signed [31:0] w_bx [4];
  logic signed [31:0] w_yx [4];
  logic signed [31:0] w_pr [4][4];
  logic signed [31:0] w_sq [4];
  logic signed [33:0] w_p [4];
  logic [32:0]        w_n;
  logic [33:0]        w_shift [4];
  logic [33:0]        w_diff [4];
  logic               w_accept;

  function automatic logic [32:0] mag34(input logic signed [33:0] v);
    return v[33] ? 33'(-v) : 33'(v);
  endfunction

  // Quotient magnitudes never exceed 2^32, so the 16-bit clamp decides on the full value.
  function automatic logic signed [15:0] sat_q(input logic [32:0] q, input logic s);
    if (s) return (q > 33'd32768) ? -16'sd32768 : -$signed(q[15:0]);
    return (q > 33'd32767) ? 16'sd32767 : $signed(q[15:0]);
  endfunction

  assign w_accept = bus.in_valid && (r_state == S_IDLE);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_bx[i] = 32'(r_b[i]);
      w_yx[i] = 32'(r_y[i]);
    end
    for (int i = 0; i < 4; i++) begin
      w_sq[i] = w_bx[i] * w_bx[i];
      for (int j = 0; j < 4; j++) w_pr[i][j] = w_bx[i] * w_yx[j];
    end
    // Conjugate folded into the signs: a = (b0, -b1, -b2, -b3).
    w_p[0] = 34'(w_pr[0][0]) + 34'(w_pr[1][1]) + 34'(w_pr[2][2]) + 34'(w_pr[3][3]);
    w_p[1] = 34'(w_pr[0][1]) - 34'(w_pr[1][0]) - 34'(w_pr[2][3]) + 34'(w_pr[3][2]);
    w_p[2] = 34'(w_pr[0][2]) + 34'(w_pr[1][3]) - 34'(w_pr[2][0]) - 34'(w_pr[3][1]);
    w_p[3] = 34'(w_pr[0][3]) - 34'(w_pr[1][2]) + 34'(w_pr[2][1]) - 34'(w_pr[3][0]);
    w_n = 33'($unsigned(w_sq[0])) + 33'($unsigned(w_sq[1]))
        + 33'($unsigned(w_sq[2])) + 33'($unsigned(w_sq[3]));
    for (int i = 0; i < 4; i++) begin
      w_shift[i] = {r_rem[i], r_mag[i][32]};
      w_diff[i]  = w_shift[i] - {1'b0, r_n};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.in_valid) w_next = S_PROD;
      S_PROD: w_next = (w_n == 33'd0) ? S_FIN : S_DIV;
      S_DIV:  if (r_cnt == 6'd32) w_next = S_FIN;
      S_FIN:  w_next = S_OUT;
      S_OUT:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_b[i]   <= '0;
        r_y[i]   <= '0;
        r_mag[i] <= '0;
        r_rem[i] <= '0;
        r_q[i]   <= '0;
        r_x[i]   <= '0;
      end
      r_sgn  <= '0;
      r_n    <= '0;
      r_cnt  <= '0;
      r_zero <= 1'b0;
      r_ovld <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_b[0] <= bus.b0; r_b[1] <= bus.b1; r_b[2] <= bus.b2; r_b[3] <= bus.b3;
          r_y[0] <= bus.y0; r_y[1] <= bus.y1; r_y[2] <= bus.y2; r_y[3] <= bus.y3;
        end
        S_PROD: begin
          for (int i = 0; i < 4; i++) begin
            r_mag[i] <= mag34(w_p[i]);
            r_sgn[i] <= w_p[i][33];
            r_rem[i] <= '0;
            r_q[i]   <= '0;
          end
          r_n    <= w_n;
          r_zero <= (w_n == 33'd0);
          r_cnt  <= '0;
        end
        // A non-negative difference (no borrow) means the trial subtraction succeeds.
        S_DIV: begin
          for (int i = 0; i < 4; i++) begin
            r_rem[i] <= w_diff[i][33] ? w_shift[i][32:0] : w_diff[i][32:0];
            r_q[i]   <= {r_q[i][31:0], ~w_diff[i][33]};
            r_mag[i] <= {r_mag[i][31:0], 1'b0};
          end
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIN: begin
          for (int i = 0; i < 4; i++)
            r_x[i] <= r_zero ? 16'sd0 : sat_q(r_q[i], r_sgn[i]);
          r_dbz  <= r_zero;
          r_ovld <= 1'b1;
        end
        S_OUT: if (bus.out_ready) r_ovld <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = r_ovld;
  assign bus.div_by_zero = r_dbz;
  assign bus.x0 = r_x[0];
  assign bus.x1 = r_x[1];
  assign bus.x2 = r_x[2];
  assign bus.x3 = r_x[3];

endmodule

// File: tb/tb_quaternion_divider.sv
// Directed and randomized bench for quaternion_divider with a Hamilton-product
// reference model computed in plain integer arithmetic.
module tb_quaternion_divider;

  typedef longint quat_t [4];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  quaternion_divider_if bus();

  quaternion_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic quat_t qmul(input quat_t a, input quat_t b);
    quat_t r;
    r[0] = a[0]*b[0] - a[1]*b[1] - a[2]*b[2] - a[3]*b[3];
    r[1] = a[0]*b[1] + a[1]*b[0] + a[2]*b[3] - a[3]*b[2];
    r[2] = a[0]*b[2] - a[1]*b[3] + a[2]*b[0] + a[3]*b[1];
    r[3] = a[0]*b[3] + a[1]*b[2] - a[2]*b[1] + a[3]*b[0];
    return r;
  endfunction

  function automatic longint norm2(input quat_t b);
    return b[0]*b[0] + b[1]*b[1] + b[2]*b[2] + b[3]*b[3];
  endfunction

  function automatic quat_t model(input quat_t b, input quat_t y);
    quat_t c, p, x;
    longint n;
    c = '{b[0], -b[1], -b[2], -b[3]};
    p = qmul(c, y);
    n = norm2(b);
    for (int k = 0; k < 4; k++) begin
      if (n == 0) x[k] = 0;
      else begin
        x[k] = p[k] / n;
        if (x[k] > 32767) x[k] = 32767;
        if (x[k] < -32768) x[k] = -32768;
      end
    end
    return x;
  endfunction

  function automatic longint rnd16();
    return longint'($signed(16'($urandom)));
  endfunction

  task automatic chk_x(input string tag, input quat_t xe);
    chk({tag, ".x0"}, bus.x0, xe[0]);
    chk({tag, ".x1"}, bus.x1, xe[1]);
    chk({tag, ".x2"}, bus.x2, xe[2]);
    chk({tag, ".x3"}, bus.x3, xe[3]);
  endtask

  task automatic run_op(input string tag, input quat_t b, input quat_t y,
                        input quat_t xe, input bit dze, input int lat,
                        input int bp, input bit busy, input bit early_rdy,
                        output quat_t xo);
    int cyc;
    bus.b0 = 16'(b[0]); bus.b1 = 16'(b[1]); bus.b2 = 16'(b[2]); bus.b3 = 16'(b[3]);
    bus.y0 = 16'(y[0]); bus.y1 = 16'(y[1]); bus.y2 = 16'(y[2]); bus.y3 = 16'(y[3]);
    bus.in_valid  = 1'b1;
    bus.out_ready = early_rdy;
    chk({tag, ".in_ready_idle"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, ".in_ready_busy"}, bus.in_ready, 0);
    cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      if (busy) begin
        bus.in_valid = (cyc >= 3 && cyc < 20) && cyc[0];
        bus.b0 = 16'(rnd16()); bus.b1 = 16'(rnd16()); bus.b2 = 16'(rnd16()); bus.b3 = 16'(rnd16());
        bus.y0 = 16'(rnd16()); bus.y1 = 16'(rnd16()); bus.y2 = 16'(rnd16()); bus.y3 = 16'(rnd16());
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({tag, ".latency"}, cyc, lat);
    chk({tag, ".out_valid"}, bus.out_valid, 1);
    chk({tag, ".div_by_zero"}, bus.div_by_zero, dze);
    chk_x(tag, xe);
    xo = '{longint'(bus.x0), longint'(bus.x1), longint'(bus.x2), longint'(bus.x3)};
    if (!early_rdy) begin
      for (int i = 0; i < bp; i++) begin
        @(posedge clk); #1;
        chk({tag, ".bp_valid"}, bus.out_valid, 1);
        chk({tag, ".bp_in_ready"}, bus.in_ready, 0);
        chk({tag, ".bp_dbz"}, bus.div_by_zero, dze);
        chk_x({tag, ".bp"}, xo);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".valid_cleared"}, bus.out_valid, 0);
    chk({tag, ".in_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    quat_t b, y, xe, xo, rt;
    bit    dz;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.b0 = '0; bus.b1 = '0; bus.b2 = '0; bus.b3 = '0;
    bus.y0 = '0; bus.y1 = '0; bus.y2 = '0; bus.y3 = '0;

    #1;
    chk("reset.in_ready", bus.in_ready, 1);
    chk("reset.out_valid", bus.out_valid, 0);
    chk("reset.dbz", bus.div_by_zero, 0);
    chk_x("reset", '{0, 0, 0, 0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    b = '{1, 0, 0, 0}; y = '{5, -3, 7, 2};
    run_op("identity", b, y, '{5, -3, 7, 2}, 1'b0, 35, 0, 1'b0, 1'b0, xo);

    b = '{0, 2, 0, 0}; y = '{0, 0, 0, 4};
    run_op("vector", b, y, '{0, 0, 2, 0}, 1'b0, 35, 0, 1'b0, 1'b1, xo);
    rt = qmul(b, xo);
    for (int k = 0; k < 4; k++) chk($sformatf("vector.roundtrip%0d", k), rt[k], y[k]);

    b = '{3, 0, 0, 0}; y = '{10, -10, 1, -1};
    run_op("trunc", b, y, '{3, -3, 0, 0}, 1'b0, 35, 0, 1'b0, 1'b0, xo);

    b = '{0, 0, 0, 0}; y = '{100, 1, 2, 3};
    run_op("zero", b, y, '{0, 0, 0, 0}, 1'b1, 2, 0, 1'b0, 1'b1, xo);

    b = '{2, 1, -1, 3}; y = '{7, -4, 9, 1};
    run_op("backpressure", b, y, model(b, y), 1'b0, 35, 10, 1'b1, 1'b0, xo);

    b = '{-1, 0, 0, 0}; y = '{-32768, 0, 0, 0};
    run_op("clamp", b, y, '{32767, 0, 0, 0}, 1'b0, 35, 0, 1'b0, 1'b0, xo);

    b = '{-32768, 0, 0, 0}; y = '{-32768, 32767, 0, 0};
    run_op("extreme", b, y, '{1, 0, 0, 0}, 1'b0, 35, 0, 1'b0, 1'b0, xo);

    // Abort an operation in the middle of the division steps.
    bus.b0 = 16'sd7; bus.b1 = 16'sd3; bus.b2 = -16'sd2; bus.b3 = 16'sd1;
    bus.y0 = 16'sd900; bus.y1 = 16'sd5; bus.y2 = 16'sd6; bus.y3 = 16'sd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset.in_ready", bus.in_ready, 1);
    chk("midreset.out_valid", bus.out_valid, 0);
    chk("midreset.dbz", bus.div_by_zero, 0);
    chk_x("midreset", '{0, 0, 0, 0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("midreset.no_output", bus.out_valid, 0);
    b = '{1, 1, 1, 1}; y = '{4, 0, 0, 0};
    run_op("after_reset", b, y, '{1, -1, -1, -1}, 1'b0, 35, 0, 1'b0, 1'b0, xo);

    for (int i = 0; i < 14; i++) begin
      if (i == 5) b = '{0, 0, 0, 0};
      else if (i % 3 == 0)
        b = '{longint'($urandom_range(0, 6)) - 3, longint'($urandom_range(0, 6)) - 3,
              longint'($urandom_range(0, 6)) - 3, longint'($urandom_range(0, 6)) - 3};
      else b = '{rnd16(), rnd16(), rnd16(), rnd16()};
      y = '{rnd16(), rnd16(), rnd16(), rnd16()};
      dz = (norm2(b) == 0);
      xe = model(b, y);
      run_op($sformatf("rand%0d", i), b, y, xe, dz, dz ? 2 : 35, i % 4,
             i[1], i[0], xo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
